// File: rtl/dfi_update_lp_sched_if.sv
// DFI sideband handshake bundle between the controller-side scheduler (master)
// and the PHY (slave): update, PHY master and low-power request/ack pairs.
interface dfi_update_lp_sched_if;
  logic       ctrlupd_req;
  logic       ctrlupd_ack;
  logic       phyupd_req;
  logic [1:0] phyupd_type;
  logic       phyupd_ack;
  logic       phymstr_req;
  logic       phymstr_ack;
  logic       lp_ctrl_req;
  logic       lp_ctrl_ack;
  logic       lp_data_req;
  logic       lp_data_ack;
  logic [5:0] lp_ctrl_wakeup;
  logic [5:0] lp_data_wakeup;

  modport master (
    output ctrlupd_req, phyupd_ack, phymstr_ack, lp_ctrl_req, lp_data_req,
           lp_ctrl_wakeup, lp_data_wakeup,
    input  ctrlupd_ack, phyupd_req, phyupd_type, phymstr_req, lp_ctrl_ack, lp_data_ack
  );

  modport slave (
    input  ctrlupd_req, phyupd_ack, phymstr_ack, lp_ctrl_req, lp_data_req,
           lp_ctrl_wakeup, lp_data_wakeup,
    output ctrlupd_ack, phyupd_req, phyupd_type, phymstr_req, lp_ctrl_ack, lp_data_ack
  );
endinterface

// File: rtl/dfi_update_lp_sched.sv
// DFI sideband scheduler: grants one of PHY update, PHY master, control update
// or low power at a time, enforces response timeouts, and holds traffic off the bus.
module dfi_update_lp_sched #(
  parameter int TPHYUPD_RESP = 16,
  parameter int TLP_RESP     = 8,
  parameter int TCTRLUPD_MIN = 4,
  parameter int TCTRLUPD_MAX = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          init_start,
  input  logic                          mc_idle,
  input  logic                          mc_ctrlupd_req,
  input  logic                          mc_lp_req,
  input  logic [5:0]                    mc_lp_wakeup,
  dfi_update_lp_sched_if.master         dfi,
  output logic                          traffic_hold,
  output logic [1:0]                    upd_type_q,
  output logic                          err_phyupd_timeout,
  output logic                          lp_rejected
);

  localparam int MAX_AB = (TPHYUPD_RESP > TLP_RESP) ? TPHYUPD_RESP : TLP_RESP;
  localparam int MAX_CD = (TCTRLUPD_MIN > TCTRLUPD_MAX) ? TCTRLUPD_MIN : TCTRLUPD_MAX;
  localparam int MAXP   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = $clog2(MAXP) + 1;

  typedef enum logic [3:0] {
    S_IDLE        = 4'd0,
    S_DRAIN_PHY   = 4'd1,
    S_PHYUPD      = 4'd2,
    S_PHYMSTR     = 4'd3,
    S_CTRLUPD     = 4'd4,
    S_CTRLUPD_REL = 4'd5,
    S_LP_WAIT     = 4'd6,
    S_LP_ACTIVE   = 4'd7,
    S_LP_REL      = 4'd8
  } state_t;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (v == {CW{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CW'(1);
    end
  endfunction

  state_t          state_q, state_d;
  logic            drain_mstr_q, drain_mstr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ack_seen_q, ack_seen_d;
  logic            ctrlupd_req_q, ctrlupd_req_d;
  logic            phyupd_ack_q, phyupd_ack_d;
  logic            phymstr_ack_q, phymstr_ack_d;
  logic            lp_req_q, lp_req_d;
  logic [5:0]      wakeup_q, wakeup_d;
  logic            hold_q, hold_d;
  logic [1:0]      upd_cap_q, upd_cap_d;
  logic            lp_rej_q, lp_rej_d;
  logic [CW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic            tmo_run_q, tmo_run_d;
  logic            err_q, err_d;
  logic            phyupd_prev_q, phyupd_prev_d;
  logic            ack_seen_now_s;

  assign ack_seen_now_s = ack_seen_q | dfi.ctrlupd_ack;

  // Handshake FSM: next state and next registered outputs
  always_comb begin
    state_d       = state_q;
    drain_mstr_d  = drain_mstr_q;
    cnt_d         = sat_inc(cnt_q);
    ack_seen_d    = ack_seen_q;
    ctrlupd_req_d = 1'b0;
    phyupd_ack_d  = 1'b0;
    phymstr_ack_d = 1'b0;
    lp_req_d      = 1'b0;
    wakeup_d      = 6'd0;
    hold_d        = 1'b0;
    upd_cap_d     = upd_cap_q;
    lp_rej_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (init_start) begin
          state_d = S_IDLE;
        end else if (dfi.phyupd_req) begin
          state_d      = S_DRAIN_PHY;
          drain_mstr_d = 1'b0;
          hold_d       = 1'b1;
        end else if (dfi.phymstr_req) begin
          state_d      = S_DRAIN_PHY;
          drain_mstr_d = 1'b1;
          hold_d       = 1'b1;
        end else if (mc_ctrlupd_req) begin
          state_d       = S_CTRLUPD;
          ctrlupd_req_d = 1'b1;
          cnt_d         = CW'(1);
          ack_seen_d    = 1'b0;
        end else if (mc_lp_req) begin
          state_d  = S_LP_WAIT;
          lp_req_d = 1'b1;
          wakeup_d = mc_lp_wakeup;
          cnt_d    = CW'(1);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN_PHY: begin
        hold_d = 1'b1;
        if (mc_idle) begin
          if (drain_mstr_q) begin
            state_d       = S_PHYMSTR;
            phymstr_ack_d = 1'b1;
          end else begin
            state_d      = S_PHYUPD;
            phyupd_ack_d = 1'b1;
            upd_cap_d    = dfi.phyupd_type;
          end
        end else begin
          state_d = S_DRAIN_PHY;
        end
      end
      S_PHYUPD: begin
        if (dfi.phyupd_req) begin
          phyupd_ack_d = 1'b1;
          hold_d       = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PHYMSTR: begin
        if (dfi.phymstr_req) begin
          phymstr_ack_d = 1'b1;
          hold_d        = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CTRLUPD: begin
        ack_seen_d = ack_seen_now_s;
        // cnt_q counts cycles ctrlupd_req has already been visible on the bus
        if ((ack_seen_now_s && (cnt_q >= CW'(TCTRLUPD_MIN))) ||
            (cnt_q >= CW'(TCTRLUPD_MAX))) begin
          state_d = S_CTRLUPD_REL;
        end else begin
          ctrlupd_req_d = 1'b1;
        end
      end
      S_CTRLUPD_REL: begin
        if (!dfi.ctrlupd_ack) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_CTRLUPD_REL;
        end
      end
      S_LP_WAIT: begin
        if (dfi.lp_ctrl_ack && dfi.lp_data_ack) begin
          state_d  = S_LP_ACTIVE;
          lp_req_d = 1'b1;
          wakeup_d = wakeup_q;
        end else if (cnt_q >= CW'(TLP_RESP)) begin
          state_d  = S_LP_REL;
          lp_rej_d = 1'b1;
        end else begin
          lp_req_d = 1'b1;
          wakeup_d = wakeup_q;
        end
      end
      S_LP_ACTIVE: begin
        if (!mc_lp_req || dfi.phyupd_req || dfi.phymstr_req) begin
          state_d = S_LP_REL;
        end else begin
          lp_req_d = 1'b1;
          wakeup_d = wakeup_q;
        end
      end
      S_LP_REL: begin
        if (!dfi.lp_ctrl_ack && !dfi.lp_data_ack) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_LP_REL;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // PHY update response timer: runs from the phyupd_req rise until the ack is granted
  always_comb begin
    phyupd_prev_d = dfi.phyupd_req;
    tmo_run_d     = tmo_run_q;
    tmo_cnt_d     = tmo_cnt_q;
    err_d         = err_q;
    if (dfi.phyupd_req && !phyupd_prev_q) begin
      tmo_run_d = 1'b1;
      tmo_cnt_d = CW'(1);
    end else if (tmo_run_q) begin
      tmo_cnt_d = sat_inc(tmo_cnt_q);
    end else begin
      tmo_cnt_d = tmo_cnt_q;
    end
    if (!tmo_run_d) begin
      tmo_run_d = 1'b0;
    end else if (phyupd_ack_d || !dfi.phyupd_req) begin
      tmo_run_d = 1'b0;
    end else if (tmo_cnt_d >= CW'(TPHYUPD_RESP)) begin
      err_d     = 1'b1;
      tmo_run_d = 1'b0;
    end else begin
      tmo_run_d = 1'b1;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      drain_mstr_q  <= 1'b0;
      cnt_q         <= '0;
      ack_seen_q    <= 1'b0;
      ctrlupd_req_q <= 1'b0;
      phyupd_ack_q  <= 1'b0;
      phymstr_ack_q <= 1'b0;
      lp_req_q      <= 1'b0;
      wakeup_q      <= 6'd0;
      hold_q        <= 1'b0;
      upd_cap_q     <= 2'd0;
      lp_rej_q      <= 1'b0;
      tmo_cnt_q     <= '0;
      tmo_run_q     <= 1'b0;
      err_q         <= 1'b0;
      phyupd_prev_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      drain_mstr_q  <= drain_mstr_d;
      cnt_q         <= cnt_d;
      ack_seen_q    <= ack_seen_d;
      ctrlupd_req_q <= ctrlupd_req_d;
      phyupd_ack_q  <= phyupd_ack_d;
      phymstr_ack_q <= phymstr_ack_d;
      lp_req_q      <= lp_req_d;
      wakeup_q      <= wakeup_d;
      hold_q        <= hold_d;
      upd_cap_q     <= upd_cap_d;
      lp_rej_q      <= lp_rej_d;
      tmo_cnt_q     <= tmo_cnt_d;
      tmo_run_q     <= tmo_run_d;
      err_q         <= err_d;
      phyupd_prev_q <= phyupd_prev_d;
    end
  end

  assign dfi.ctrlupd_req    = ctrlupd_req_q;
  assign dfi.phyupd_ack     = phyupd_ack_q;
  assign dfi.phymstr_ack    = phymstr_ack_q;
  assign dfi.lp_ctrl_req    = lp_req_q;
  assign dfi.lp_data_req    = lp_req_q;
  assign dfi.lp_ctrl_wakeup = wakeup_q;
  assign dfi.lp_data_wakeup = wakeup_q;
  assign traffic_hold       = hold_q;
  assign upd_type_q         = upd_cap_q;
  assign err_phyupd_timeout = err_q;
  assign lp_rejected        = lp_rej_q;

endmodule
